// File: rtl/demux1x4_4b_seq_pkg.sv
// demux1x4_4b_seq_pkg: lane indices, FSM states and widths shared by the nibble distributor.
package demux1x4_4b_seq_pkg;
  localparam int NIBBLE_W = 4;
  localparam logic [1:0] LANE_A = 2'b00;
  localparam logic [1:0] LANE_B = 2'b01;
  localparam logic [1:0] LANE_C = 2'b10;
  localparam logic [1:0] LANE_D = 2'b11;
  typedef enum logic {FILL, HOLD} state_t;
endpackage

// File: rtl/demux1x4_4b_seq_lane_reg.sv
// lane_reg_4b: nibble holding register with write enable and async reset.
module lane_reg_4b
  import demux1x4_4b_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [NIBBLE_W-1:0] d,
  output logic [NIBBLE_W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (we) q <= d;
endmodule

// File: rtl/demux1x4_4b_seq.sv
// demux1x4_4b_seq: registered 1-to-4 nibble distributor with frame tracking.
// Define DEMUX_AUTO_SEL_EN to fill lanes a..d from an internal pointer instead of select.
module demux1x4_4b_seq
  import demux1x4_4b_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [NIBBLE_W-1:0] in_data,
  input  logic [1:0]          select,
  input  logic                clear,
  output logic                in_ready,
  output logic [NIBBLE_W-1:0] out_a,
  output logic [NIBBLE_W-1:0] out_b,
  output logic [NIBBLE_W-1:0] out_c,
  output logic [NIBBLE_W-1:0] out_d,
  output logic [3:0]          lane_vld,
  output logic                frame_done,
  output logic                ovr
);
  state_t state;
  logic [1:0] sel;
  logic [3:0] dec, we;
  logic acc;
`ifdef DEMUX_AUTO_SEL_EN
  logic [1:0] ptr;
  logic unused_select;
  assign unused_select = ^select;
  assign sel = ptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= 2'b00;
    else if (clear) ptr <= 2'b00;
    else if (acc) ptr <= ptr + 2'b01;
`else
  assign sel = select;
`endif
  assign in_ready = (state == FILL) && !clear;
  assign acc = in_valid && in_ready;
  assign dec = 4'b0001 << sel;
  assign we = acc ? dec : 4'b0000;
  assign frame_done = (state == HOLD);
  lane_reg_4b u_a (.clk(clk), .rst(rst), .we(we[LANE_A]), .d(in_data), .q(out_a));
  lane_reg_4b u_b (.clk(clk), .rst(rst), .we(we[LANE_B]), .d(in_data), .q(out_b));
  lane_reg_4b u_c (.clk(clk), .rst(rst), .we(we[LANE_C]), .d(in_data), .q(out_c));
  lane_reg_4b u_d (.clk(clk), .rst(rst), .we(we[LANE_D]), .d(in_data), .q(out_d));
  // clear wins over a write because it already forces in_ready low
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= FILL;
      lane_vld <= 4'b0000;
      ovr      <= 1'b0;
    end else if (clear) begin
      state    <= FILL;
      lane_vld <= 4'b0000;
      ovr      <= 1'b0;
    end else if (acc) begin
      lane_vld <= lane_vld | dec;
      if ((lane_vld & dec) != 4'b0000) ovr <= 1'b1;
      if ((lane_vld | dec) == 4'b1111) state <= HOLD;
    end
endmodule

// File: tb/tb_demux1x4_4b_seq.sv
// tb_demux1x4_4b_seq: directed checks of fill, overwrite, hold/clear, clear priority and async reset.
module tb_demux1x4_4b_seq;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, clear = 1'b0, in_ready, frame_done, ovr;
  logic [3:0] in_data = 4'h0, out_a, out_b, out_c, out_d, lane_vld;
  logic [1:0] select = 2'b00;
  int vectors = 0, miscompares = 0;

  demux1x4_4b_seq dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .select(select), .clear(clear), .in_ready(in_ready), .out_a(out_a), .out_b(out_b),
    .out_c(out_c), .out_d(out_d), .lane_vld(lane_vld), .frame_done(frame_done), .ovr(ovr));

  always #5 clk = ~clk;

  task automatic wr(input logic [1:0] s, input logic [3:0] d);
    select = s; in_data = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({out_a, out_b, out_c, out_d, lane_vld, frame_done, ovr, in_ready} !== {20'h0, 3'b001}) begin
      miscompares++;
      $display("FAIL reset: got %h %h %h %h vld=%b fd=%b ovr=%b rdy=%b want all 0, rdy=1",
        out_a, out_b, out_c, out_d, lane_vld, frame_done, ovr, in_ready);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_explicit_fill();
    wr(2'b01, 4'hA);
    vectors++;
    if ({lane_vld, frame_done, out_b} !== {4'b0010, 1'b0, 4'hA}) begin
      miscompares++;
      $display("FAIL fill_first: vld=%b fd=%b b=%h want 0010 0 a", lane_vld, frame_done, out_b);
    end
    wr(2'b10, 4'h2);
    wr(2'b11, 4'h1);
    vectors++;
    if ({lane_vld, frame_done, in_ready} !== {4'b1110, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL fill_third: vld=%b fd=%b rdy=%b want 1110 0 1", lane_vld, frame_done, in_ready);
    end
    wr(2'b00, 4'h8);
    vectors++;
    if ({out_a, out_b, out_c, out_d} !== 16'h8A21) begin
      miscompares++;
      $display("FAIL fill_data: got %h%h%h%h want 8a21", out_a, out_b, out_c, out_d);
    end
    vectors++;
    if ({lane_vld, frame_done, ovr, in_ready} !== {4'b1111, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL fill_done: vld=%b fd=%b ovr=%b rdy=%b want 1111 1 0 0", lane_vld, frame_done, ovr, in_ready);
    end
  endtask

  task automatic test_hold_clear();
    wr(2'b00, 4'hF);
    vectors++;
    if ({out_a, out_b, out_c, out_d, lane_vld, frame_done, in_ready} !== {16'h8A21, 4'b1111, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL hold_ignore: got %h%h%h%h vld=%b fd=%b rdy=%b want 8a21 1111 1 0",
        out_a, out_b, out_c, out_d, lane_vld, frame_done, in_ready);
    end
    clear = 1'b1; #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_comb_ready: got %b want 0", in_ready);
    end
    @(posedge clk); #1; clear = 1'b0; #1;
    vectors++;
    if ({out_a, out_b, out_c, out_d, lane_vld, frame_done, ovr, in_ready} !== {16'h8A21, 4'b0000, 3'b001}) begin
      miscompares++;
      $display("FAIL hold_clear: got %h%h%h%h vld=%b fd=%b ovr=%b rdy=%b want 8a21 0000 0 0 1",
        out_a, out_b, out_c, out_d, lane_vld, frame_done, ovr, in_ready);
    end
  endtask

  task automatic test_overwrite();
    wr(2'b01, 4'h3);
    vectors++;
    if ({out_b, ovr} !== {4'h3, 1'b0}) begin
      miscompares++;
      $display("FAIL overwrite_first: b=%h ovr=%b want 3 0", out_b, ovr);
    end
    wr(2'b01, 4'h7);
    vectors++;
    if ({out_b, lane_vld, ovr, frame_done} !== {4'h7, 4'b0010, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL overwrite: b=%h vld=%b ovr=%b fd=%b want 7 0010 1 0", out_b, lane_vld, ovr, frame_done);
    end
  endtask

  task automatic test_clear_priority();
    clear = 1'b1; in_valid = 1'b1; select = 2'b00; in_data = 4'h5; #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_prio_ready: got %b want 0", in_ready);
    end
    @(posedge clk); #1; clear = 1'b0; in_valid = 1'b0;
    vectors++;
    if ({out_a, out_b, lane_vld, ovr} !== {4'h8, 4'h7, 4'b0000, 1'b0}) begin
      miscompares++;
      $display("FAIL clear_prio: a=%h b=%h vld=%b ovr=%b want 8 7 0000 0", out_a, out_b, lane_vld, ovr);
    end
  endtask

  task automatic test_back_to_back();
    wr(2'b11, 4'h4); wr(2'b10, 4'h3); wr(2'b01, 4'h2); wr(2'b00, 4'h1);
    vectors++;
    if ({out_a, out_b, out_c, out_d, frame_done, ovr} !== {16'h1234, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_frame1: got %h%h%h%h fd=%b ovr=%b want 1234 1 0", out_a, out_b, out_c, out_d, frame_done, ovr);
    end
    do_clear();
    wr(2'b00, 4'hC);
    vectors++;
    if ({out_a, lane_vld, frame_done} !== {4'hC, 4'b0001, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_frame2: a=%h vld=%b fd=%b want c 0001 0", out_a, lane_vld, frame_done);
    end
  endtask

  task automatic test_async_reset();
    wr(2'b10, 4'h9);
    #2 rst = 1'b1; #1;
    vectors++;
    if ({out_a, out_b, out_c, out_d, lane_vld, frame_done, ovr, in_ready} !== {20'h0, 3'b001}) begin
      miscompares++;
      $display("FAIL async_reset: got %h%h%h%h vld=%b fd=%b ovr=%b rdy=%b want 0 0000 0 0 1",
        out_a, out_b, out_c, out_d, lane_vld, frame_done, ovr, in_ready);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef DEMUX_AUTO_SEL_EN
  task automatic test_auto();
    select = 2'($urandom); wr(2'($urandom), 4'h6);
    wr(2'($urandom), 4'h7); wr(2'($urandom), 4'hA); wr(2'($urandom), 4'h2);
    vectors++;
    if ({out_a, out_b, out_c, out_d, frame_done, ovr} !== {16'h67A2, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL auto_fill: got %h%h%h%h fd=%b ovr=%b want 67a2 1 0", out_a, out_b, out_c, out_d, frame_done, ovr);
    end
    wr(2'b00, 4'h3);
    do_clear();
    wr(2'b00, 4'h3);
    wr(2'b00, 4'h4);
    do_clear();
    wr(2'b11, 4'h5);
    vectors++;
    if ({out_a, out_b, lane_vld} !== {4'h5, 4'h4, 4'b0001}) begin
      miscompares++;
      $display("FAIL auto_ptr_clear: a=%h b=%h vld=%b want 5 4 0001", out_a, out_b, lane_vld);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef DEMUX_AUTO_SEL_EN
    test_auto();
`else
    test_explicit_fill();
    test_hold_clear();
    test_overwrite();
    test_clear_priority();
    test_back_to_back();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
